// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: bus widths, request layout
// and FSM state encodings.
package dmem_responder_pkg;

  localparam int EXM_DCACHE_WD = 106;
  localparam int EXM_DCACHE_RD = 34;

  // Request bus layout, MSB first; a cast from the flat bus yields the fields.
  typedef struct packed {
    logic        valid;
    logic        op;          // 0 = read, 1 = write
    logic [31:0] addr;
    logic        uncached;
    logic [3:0]  awstrb;
    logic [31:0] wdata;
    logic        cacop_en;
    logic [1:0]  cacop_code;
    logic [31:0] cacop_addr;
  } dreq_t;

  typedef struct packed {
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
  } drsp_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/dmem_sram.sv
// DEPTH x 32 word RAM with per-byte write strobes and asynchronous read.
// Contents are not reset.
module dmem_sram #(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-cache side memory responder: accepts read/write requests on a valid/ready
// handshake and returns read data after RD_LAT cycles.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [EXM_DCACHE_WD-1:0] dcache_wdata_bus,
  output logic [EXM_DCACHE_RD-1:0] dcache_rdata_bus,
  input  logic                     hold
);

  localparam int AW = $clog2(DEPTH);
  // Counter holds the number of WAIT cycles still to run, including the current one.
  localparam logic [3:0] CNT_LOAD = (RD_LAT > 1) ? 4'(RD_LAT - 1) : 4'd0;

  // Handshake: a request is taken on a rising edge where valid and ready are both 1.
  // ready never depends on valid, so there is no combinational loop through the bus.
  dreq_t       req;
  drsp_t       rsp;
  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] cap;
  logic        ready_en;
  logic        ready;
  logic        hs;
  logic        rd_hs;
  logic        wr_en;
  logic [31:0] mem_rdata;
  logic        unused_bits;

  assign req = dreq_t'(dcache_wdata_bus);

  assign ready = ready_en & ~hold & (state != ST_WAIT);
  assign hs    = req.valid & ready;
  assign rd_hs = hs & ~req.op & ~req.cacop_en;
  assign wr_en = hs &  req.op & ~req.cacop_en;

  dmem_sram #(.DEPTH(DEPTH)) u_sram (
    .clk   (clk),
    .we    (wr_en),
    .wstrb (req.awstrb),
    .addr  (req.addr[AW+1:2]),
    .wdata (req.wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      cap      <= 32'd0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (rd_hs && (RD_LAT > 0)) begin
            cap   <= mem_rdata;
            cnt   <= CNT_LOAD;
            state <= (RD_LAT == 1) ? ST_RESP : ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= ST_RESP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rsp       = '0;
    rsp.ready = ready;
    if (RD_LAT == 0) begin
      rsp.rvalid = rd_hs;
      rsp.rdata  = rd_hs ? mem_rdata : 32'd0;
    end else begin
      rsp.rvalid = (state == ST_RESP);
      rsp.rdata  = (state == ST_RESP) ? cap : 32'd0;
    end
  end

  assign dcache_rdata_bus = rsp;

  // Uncached behaves as cached; cacop code/address and out-of-range address bits are don't-care.
  assign unused_bits = ^{req.uncached, req.cacop_code, req.cacop_addr,
                         req.addr[1:0], req.addr[31:AW+2]};

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances cover latency 2, latency 0,
// a 16-word wrap/stall case and latency 4 with reset during a pending read.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic                     clk;
  logic                     rstn [4];
  logic                     hold [4];
  logic [EXM_DCACHE_WD-1:0] wbus [4];
  logic [EXM_DCACHE_RD-1:0] rbus [4];

  logic [31:0] exp_q[$];
  int          n_vec;
  int          n_err;

  dmem_responder #(.DEPTH(1024), .RD_LAT(2)) dut_l2 (
    .clk(clk), .resetn(rstn[0]), .dcache_wdata_bus(wbus[0]), .dcache_rdata_bus(rbus[0]), .hold(hold[0]));
  dmem_responder #(.DEPTH(1024), .RD_LAT(0)) dut_l0 (
    .clk(clk), .resetn(rstn[1]), .dcache_wdata_bus(wbus[1]), .dcache_rdata_bus(rbus[1]), .hold(hold[1]));
  dmem_responder #(.DEPTH(16), .RD_LAT(1)) dut_w16 (
    .clk(clk), .resetn(rstn[2]), .dcache_wdata_bus(wbus[2]), .dcache_rdata_bus(rbus[2]), .hold(hold[2]));
  dmem_responder #(.DEPTH(1024), .RD_LAT(4)) dut_l4 (
    .clk(clk), .resetn(rstn[3]), .dcache_wdata_bus(wbus[3]), .dcache_rdata_bus(rbus[3]), .hold(hold[3]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    case (d)
      0: return 2;
      1: return 0;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [EXM_DCACHE_WD-1:0] pack(input logic op, input logic [31:0] addr,
                                                     input logic [3:0] strb, input logic [31:0] wdata,
                                                     input logic cacop);
    dreq_t r;
    r.valid      = 1'b1;
    r.op         = op;
    r.addr       = addr;
    r.uncached   = 1'($urandom_range(0, 1));
    r.awstrb     = strb;
    r.wdata      = wdata;
    r.cacop_en   = cacop;
    r.cacop_code = 2'($urandom_range(0, 3));
    r.cacop_addr = $urandom;
    return r;
  endfunction

  // driver tasks
  task automatic wait_ready(input int d, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rbus[d][33] === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    n_vec++;
    n_err++;
    $display("FAIL %s: ready timeout on dut %0d, got 0 required 1", name, d);
  endtask

  task automatic do_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic cacop, input string name);
    bit ok;
    wbus[d] = pack(1'b1, addr, strb, data, cacop);
    wait_ready(d, name, ok);
    if (!ok) begin
      wbus[d] = '0;
      return;
    end
    if (lat_of(d) == 0) begin
      n_vec++;
      if (rbus[d][32] !== 1'b0) begin
        n_err++;
        $display("FAIL %s: rvalid on write, got %b required 0", name, rbus[d][32]);
      end
    end
    @(posedge clk);
    #1 wbus[d] = '0;
    if (lat_of(d) > 0) begin
      @(negedge clk);
      n_vec++;
      if (rbus[d][33:32] !== 2'b10) begin
        n_err++;
        $display("FAIL %s: ready/rvalid after write, got %b required 10", name, rbus[d][33:32]);
      end
    end
  endtask

  task automatic do_read(input int d, input logic [31:0] addr, input logic [31:0] exp,
                         input string name);
    bit ok;
    logic [31:0] e;
    exp_q.push_back(exp);
    wbus[d] = pack(1'b0, addr, 4'($urandom), $urandom, 1'b0);
    wait_ready(d, name, ok);
    if (!ok) begin
      wbus[d] = '0;
      void'(exp_q.pop_front());
      return;
    end
    if (lat_of(d) == 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (rbus[d] !== {2'b11, e}) begin
        n_err++;
        $display("FAIL %s: zero-latency response got %h required %h", name, rbus[d], {2'b11, e});
      end
      @(posedge clk);
      #1 wbus[d] = '0;
      return;
    end
    @(posedge clk);
    #1 wbus[d] = '0;
    for (int i = 1; i <= lat_of(d); i++) begin
      @(negedge clk);
      if (i < lat_of(d)) begin
        n_vec++;
        if (rbus[d] !== '0) begin
          n_err++;
          $display("FAIL %s: wait cycle %0d bus got %h required 0", name, i, rbus[d]);
        end
      end else begin
        e = exp_q.pop_front();
        n_vec++;
        if (rbus[d][32:0] !== {1'b1, e}) begin
          n_err++;
          $display("FAIL %s: response got rvalid=%b rdata=%h required rvalid=1 rdata=%h",
                   name, rbus[d][32], rbus[d][31:0], e);
        end
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    for (int d = 0; d < 4; d++) begin
      rstn[d] = 1'b0;
      hold[d] = 1'b0;
      wbus[d] = '0;
    end
    wbus[1] = pack(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 4; d++) begin
      n_vec++;
      if (rbus[d] !== '0) begin
        n_err++;
        $display("FAIL reset_hold: dut %0d bus got %h required 0", d, rbus[d]);
      end
    end
    wbus[1] = '0;
    @(negedge clk);
    for (int d = 0; d < 4; d++) rstn[d] = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      n_vec++;
      if (rbus[d] !== '0) begin
        n_err++;
        $display("FAIL reset_release: dut %0d bus got %h required 0", d, rbus[d]);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      n_vec++;
      if (rbus[d] !== {1'b1, 33'd0}) begin
        n_err++;
        $display("FAIL reset_first_edge: dut %0d bus got %h required %h", d, rbus[d], {1'b1, 33'd0});
      end
    end
  endtask

  task automatic test_write_read();
    do_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "wr_10");
    do_read(0, 32'h10, 32'hDEADBEEF, "rd_10");
  endtask

  task automatic test_byte_strobe();
    do_write(0, 32'h40, 32'h11223344, 4'hF, 1'b0, "strb_init");
    do_write(0, 32'h40, 32'hAABBCCDD, 4'b0101, 1'b0, "strb_wr");
    do_read(0, 32'h40, 32'h11BB33DD, "strb_rd");
    do_write(0, 32'h40, 32'h55555555, 4'b0000, 1'b0, "strb_zero");
    do_read(0, 32'h43, 32'h11BB33DD, "strb_zero_rd");
  endtask

  task automatic test_cacop();
    do_write(0, 32'h10, 32'h0BADF00D, 4'hF, 1'b1, "cacop_wr");
    do_write(0, 32'h10, 32'h0, 4'h0, 1'b1, "cacop_rd_op");
    do_read(0, 32'h10, 32'hDEADBEEF, "cacop_after");
  endtask

  task automatic test_zero_latency();
    do_write(1, 32'h8, 32'h12345678, 4'hF, 1'b0, "l0_wr");
    do_read(1, 32'h8, 32'h12345678, "l0_rd");
    do_write(1, 32'h100C, 32'hA5A5A5A5, 4'hF, 1'b0, "l0_wr_wrap");
    do_read(1, 32'h0C, 32'hA5A5A5A5, "l0_rd_wrap");
  endtask

  task automatic test_wrap_stall();
    do_write(2, 32'h44, 32'hCAFEF00D, 4'hF, 1'b0, "w16_wr");
    hold[2] = 1'b1;
    wbus[2] = pack(1'b0, 32'h04, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (rbus[2] !== '0) begin
        n_err++;
        $display("FAIL stall_%0d: bus got %h required 0", i, rbus[2]);
      end
    end
    hold[2] = 1'b0;
    do_read(2, 32'h04, 32'hCAFEF00D, "w16_rd_wrap");
  endtask

  task automatic test_back_to_back();
    do_write(0, 32'h200, 32'h01020304, 4'hF, 1'b0, "b2b_wr0");
    do_write(0, 32'h204, 32'h05060708, 4'hF, 1'b0, "b2b_wr1");
    do_read(0, 32'h200, 32'h01020304, "b2b_rd0");
    do_read(0, 32'h204, 32'h05060708, "b2b_rd1");
    do_write(0, 32'h200, 32'hFFFF0000, 4'b1100, 1'b0, "b2b_wr_resp");
    do_read(0, 32'h200, 32'hFFFF0304, "b2b_rd2");
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    do_write(3, 32'h20, 32'h600DCAFE, 4'hF, 1'b0, "l4_wr");
    wbus[3] = pack(1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
    wait_ready(3, "l4_rd", ok);
    if (!ok) begin
      wbus[3] = '0;
      return;
    end
    @(posedge clk);
    #1 wbus[3] = '0;
    @(negedge clk);
    n_vec++;
    if (rbus[3] !== '0) begin
      n_err++;
      $display("FAIL l4_wait: bus got %h required 0", rbus[3]);
    end
    rstn[3] = 1'b0;
    #1;
    n_vec++;
    if (rbus[3] !== '0) begin
      n_err++;
      $display("FAIL l4_reset_now: bus got %h required 0", rbus[3]);
    end
    @(posedge clk);
    @(negedge clk);
    rstn[3] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_vec++;
      if (rbus[3] !== {1'b1, 33'd0}) begin
        n_err++;
        $display("FAIL l4_after_reset_%0d: bus got %h required %h", i, rbus[3], {1'b1, 33'd0});
      end
    end
    do_read(3, 32'h20, 32'h600DCAFE, "l4_rd_again");
  endtask

  task automatic test_random();
    logic [31:0] mdl [8];
    logic [31:0] a;
    logic [31:0] dat;
    logic [3:0]  s;
    int          k;
    for (int j = 0; j < 8; j++) begin
      mdl[j] = $urandom;
      do_write(0, 32'h300 + 32'(4 * j), mdl[j], 4'hF, 1'b0, "rnd_init");
    end
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 7);
      a = {20'($urandom), 12'h300 + 12'(4 * k)};
      if ($urandom_range(0, 1) == 1) begin
        dat = $urandom;
        s   = 4'($urandom_range(0, 15));
        for (int b = 0; b < 4; b++) if (s[b]) mdl[k][8*b +: 8] = dat[8*b +: 8];
        do_write(0, a, dat, s, 1'b0, "rnd_wr");
      end else begin
        do_read(0, a, mdl[k], "rnd_rd");
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_write_read();
    test_byte_strobe();
    test_cacop();
    test_zero_latency();
    test_wrap_stall();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, the number of 32-bit words stored; a power of two from 16 to 65536.
REQ-002 SHALL have parameter RD_LAT, default 1, the number of cycles from read acceptance to rvalid; range 0..15.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state is on the rising edge.
REQ-004 SHALL have port resetn, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-005 SHALL have port dcache_wdata_bus, input, EXM_DCACHE_WD (106) bits, the request bus, MSB first: {valid, op(0 = read, 1 = write), addr[31:0], uncached, awstrb[3:0], wdata[31:0], cacop_en, cacop_code[1:0], cacop_addr[31:0]}.
REQ-006 SHALL have port dcache_rdata_bus, output, EXM_DCACHE_RD (34) bits, the response bus, MSB first: {ready, rvalid, rdata[31:0]}.
REQ-007 SHALL have port hold, input, 1 bit; while high, ready is forced low (stall injection).

Function
REQ-008 SHALL accept a request in any cycle where valid and ready are both 1 (the handshake); without a handshake, request fields are ignored.
REQ-009 SHALL index words with addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH*4; addr[1:0] is ignored.
REQ-010 SHALL, on a write handshake, update byte lane i of the indexed word from wdata[8i+7:8i] for each set awstrb[i], at the same clock edge; write completion is the handshake itself and produces no rvalid.
REQ-011 SHALL, on a read handshake, capture the full indexed word, with no sub-word shifting; the consumer extracts bytes and halfwords.
REQ-012 SHALL, when RD_LAT = 0, drive rvalid = 1 and rdata combinationally in the handshake cycle, and keep ready high for back-to-back requests.
REQ-013 SHALL, when RD_LAT ≥ 1, move the FSM through IDLE -> WAIT on a read handshake.
REQ-014 SHALL, when RD_LAT ≥ 1, load a down-counter with RD_LAT−1 on that handshake and, in WAIT, decrement it each cycle.
REQ-015 SHALL, when RD_LAT ≥ 1, go WAIT -> RESP when the counter is 0 and the next edge arrives, and RESP -> IDLE after exactly one cycle.
REQ-016 SHALL, when RD_LAT = 1, go IDLE -> RESP directly.
REQ-017 SHALL, in RESP, drive rvalid = 1 for exactly one cycle with the captured word.
REQ-018 SHALL keep ready = ~hold in IDLE and RESP, and ready = 0 in WAIT; a handshake in RESP is a new request, with RESP -> WAIT/RESP for a read and RESP -> IDLE for a write.
REQ-019 SHALL return read data reflecting every write handshaken in any earlier cycle, with no stale read after write.
REQ-020 SHALL drive rdata = 0 whenever rvalid = 0.
REQ-021 SHALL treat uncached = 1 exactly as cached.
REQ-022 SHALL, on a handshake with cacop_en = 1, complete it as a no-op: no memory update, no rvalid, regardless of op.
REQ-023 SHALL change nothing when hold rises while in WAIT; the pending read still completes on schedule.
REQ-024 SHALL ignore awstrb and wdata on reads; a write with awstrb = 0 completes with no memory change.

Reset
REQ-025 SHALL, while resetn = 0, hold ready = 0, rvalid = 0, rdata = 0, FSM = IDLE and counter = 0, independent of clk.
REQ-026 SHALL, when reset is asserted during WAIT or RESP, drop the pending read; no rvalid appears after release.
REQ-027 SHALL NOT reset memory contents; they are undefined until written.
REQ-028 SHALL allow ready to rise on the first clk edge after resetn deasserts (hold = 0).

Structure
REQ-029 SHALL take EXM_DCACHE_WD, EXM_DCACHE_RD and the field bit offsets from define.vh; these are not redefined locally.
REQ-030 SHALL define the FSM state encodings (IDLE, WAIT, RESP) in the shared package.
REQ-031 SHALL place storage in one sub-module, dmem_sram, a DEPTH×32 RAM with a 4-bit byte-write strobe and asynchronous read.
REQ-032 SHALL contain the FSM, counter, capture register and bus pack/unpack in dmem_responder.

Verification
REQ-033 SHALL cover write then read: RD_LAT = 2; write addr 0x10, wdata 0xDEADBEEF, awstrb 0xF; then read 0x10 -> ready low for 1 cycle, rvalid one cycle at handshake+2, rdata 0xDEADBEEF.
REQ-034 SHALL cover byte strobes: word 0x40 = 0x11223344; write wdata 0xAABBCCDD, awstrb 0b0101; read 0x40 -> 0x11BB33DD.
REQ-035 SHALL cover zero latency: RD_LAT = 0; write 0x8 = 0x12345678, then read 0x8 in the next cycle -> rvalid and rdata 0x12345678 in the handshake cycle; ready stays 1.
REQ-036 SHALL cover wrap and stall: DEPTH = 16; write 0x44 = 0xCAFEF00D; hold = 1 for 3 cycles with valid high on a read of 0x04 -> no handshake; then hold = 0 -> rdata 0xCAFEF00D.
REQ-037 SHALL cover cacop: cacop_en = 1, op = 1, addr 0x10 -> handshake, memory unchanged (a later read of 0x10 returns the prior value), no rvalid.
REQ-038 SHALL cover reset mid-read: RD_LAT = 4; read accepted, resetn low for 1 cycle in WAIT -> all outputs 0 immediately, no rvalid after release, ready = 1 on the first edge after release.
